// File: rtl/vote_pkg.sv
// ---------------------------------------------------------------------------
// vote_pkg
// Shared types and helpers for the sequential vote tallier.
//   state_t      : controller state encoding (IDLE/COLLECT/SCAN/DONE)
//   onehot_check : reports whether a ballot vector has exactly one bit set
//                  and, if so, which bit it is
//   clog2_min1   : ceil(log2(n)) clamped to at least 1, used for index widths
// ---------------------------------------------------------------------------
package vote_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SCAN    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Ballots are zero-extended to this width before decoding, so the
    // tallier supports at most ONEHOT_MAX candidates.
    localparam int ONEHOT_MAX   = 64;
    localparam int ONEHOT_IDX_W = 6;

    // Counts the set bits; idx ends up holding the highest set bit, which is
    // the only set bit whenever the function returns 1.
    function automatic logic onehot_check(input  logic [ONEHOT_MAX-1:0]   vec,
                                          output logic [ONEHOT_IDX_W-1:0] idx);
        int ones;
        ones = 0;
        idx  = '0;
        for (int k = 0; k < ONEHOT_MAX; k++) begin
            if (vec[k]) begin
                ones++;
                idx = ONEHOT_IDX_W'(k);
            end
        end
        return (ones == 1);
    endfunction

    // A two-candidate election still needs a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vote_counter_sat.sv
// ---------------------------------------------------------------------------
// vote_counter_sat
// W-bit up-counter with synchronous clear and saturation at all-ones.
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset (counter -> 0)
//   clr_i  : synchronous clear, wins over inc_i
//   inc_i  : add one unless already at all-ones
//   cnt_o  : current count
// ---------------------------------------------------------------------------
module vote_counter_sat #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Clear has priority so a new election never inherits a stray increment
    // from a ballot that arrived in the same cycle as start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vote_tally_seq.sv
// ---------------------------------------------------------------------------
// vote_tally_seq
// Streaming plurality/majority vote tallier. One-hot ballots arrive over a
// valid/ready handshake and are counted per candidate; on close (or when the
// voter limit is hit) the tallies are scanned one candidate per cycle to
// find the winner, a tie flag and a strict-majority flag.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : pulse, clear everything and open an election
//   close         : pulse, stop collecting ballots
//   ballot_valid  : ballot present on 'ballot'
//   ballot_ready  : ballot is accepted this cycle
//   ballot        : one-hot candidate selection
//   accepted_cnt  : well-formed ballots counted
//   rejected_cnt  : malformed ballots consumed (saturating)
//   busy          : collecting or scanning
//   result_valid  : results below are final
//   winner_idx    : lowest index among the highest tallies
//   winner_cnt    : tally of the winner
//   tie           : another candidate shares winner_cnt
//   majority      : 2*winner_cnt > accepted_cnt
// ---------------------------------------------------------------------------
module vote_tally_seq
    import vote_pkg::*;
#(
    parameter int NUM_CAND   = 4,
    parameter int MAX_VOTERS = 15,
    parameter int CNT_W      = $clog2(MAX_VOTERS + 1),
    parameter int IDX_W      = clog2_min1(NUM_CAND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                close,
    input  logic                ballot_valid,
    output logic                ballot_ready,
    input  logic [NUM_CAND-1:0] ballot,
    output logic [CNT_W-1:0]    accepted_cnt,
    output logic [CNT_W-1:0]    rejected_cnt,
    output logic                busy,
    output logic                result_valid,
    output logic [IDX_W-1:0]    winner_idx,
    output logic [CNT_W-1:0]    winner_cnt,
    output logic                tie,
    output logic                majority
);

    state_t                  state_q;
    logic [IDX_W-1:0]        scanIdx_q;
    logic [IDX_W-1:0]        winnerIdx_q, winnerIdx_d;
    logic [CNT_W-1:0]        winnerCnt_q, winnerCnt_d;
    logic                    tie_q, tie_d;
    logic                    majority_q, majority_d;

    logic [ONEHOT_MAX-1:0]   ballotWide;
    logic [ONEHOT_IDX_W-1:0] ballotIdx;
    logic                    isOnehot;
    logic                    handshake;
    logic [NUM_CAND-1:0]     tallyInc;
    logic [CNT_W-1:0]        tally [NUM_CAND];
    logic [CNT_W-1:0]        candCnt;
    logic                    lastCand;
    logic                    votersFull;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_VOTERS);

    // Decode the incoming ballot into "well formed?" plus the chosen index.
    always_comb begin
        ballotWide               = '0;
        ballotWide[NUM_CAND-1:0] = ballot;
        ballotIdx                = '0;
        isOnehot                 = onehot_check(ballotWide, ballotIdx);
    end

    // Route a well-formed handshake to exactly one candidate's tally.
    always_comb begin
        tallyInc = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            tallyInc[c] = handshake && isOnehot && (int'(ballotIdx) == c);
        end
    end

    assign votersFull   = (accepted_cnt == MAX_CNT);
    assign ballot_ready = (state_q == COLLECT) && (accepted_cnt < MAX_CNT);
    assign handshake    = ballot_valid && ballot_ready;

    // One saturating counter per candidate plus accepted and rejected totals;
    // start clears all of them in any state.
    for (genvar g = 0; g < NUM_CAND; g++) begin : gTally
        vote_counter_sat #(.W(CNT_W)) uTally (
            .clk   (clk),
            .rst   (rst),
            .clr_i (start),
            .inc_i (tallyInc[g]),
            .cnt_o (tally[g])
        );
    end

    vote_counter_sat #(.W(CNT_W)) uAccepted (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .inc_i (handshake && isOnehot),
        .cnt_o (accepted_cnt)
    );

    vote_counter_sat #(.W(CNT_W)) uRejected (
        .clk   (clk),
        .rst   (rst),
        .clr_i (start),
        .inc_i (handshake && !isOnehot),
        .cnt_o (rejected_cnt)
    );

    // One scan step: compare the candidate under the scan pointer with the
    // running winner. Equal tallies keep the earlier (lower) index and flag a
    // tie; a strictly larger tally takes over and clears the tie. Majority is
    // evaluated on the post-step winner so it is ready as DONE is entered.
    always_comb begin
        candCnt     = tally[scanIdx_q];
        lastCand    = (scanIdx_q == IDX_W'(NUM_CAND - 1));
        winnerIdx_d = winnerIdx_q;
        winnerCnt_d = winnerCnt_q;
        tie_d       = tie_q;
        if (scanIdx_q == '0) begin
            winnerIdx_d = '0;
            winnerCnt_d = candCnt;
            tie_d       = 1'b0;
        end else if (candCnt > winnerCnt_q) begin
            winnerIdx_d = scanIdx_q;
            winnerCnt_d = candCnt;
            tie_d       = 1'b0;
        end else if (candCnt == winnerCnt_q) begin
            tie_d       = 1'b1;
        end
        majority_d = ({winnerCnt_d, 1'b0} > {1'b0, accepted_cnt});
    end

    // Election controller. start restarts from any state; close only matters
    // while collecting, and a full voter roll ends collection on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            scanIdx_q   <= '0;
            winnerIdx_q <= '0;
            winnerCnt_q <= '0;
            tie_q       <= 1'b0;
            majority_q  <= 1'b0;
        end else if (start) begin
            state_q     <= COLLECT;
            scanIdx_q   <= '0;
            winnerIdx_q <= '0;
            winnerCnt_q <= '0;
            tie_q       <= 1'b0;
            majority_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                COLLECT: begin
                    if (close || votersFull) begin
                        state_q   <= SCAN;
                        scanIdx_q <= '0;
                    end
                end
                SCAN: begin
                    winnerIdx_q <= winnerIdx_d;
                    winnerCnt_q <= winnerCnt_d;
                    tie_q       <= tie_d;
                    if (lastCand) begin
                        majority_q <= majority_d;
                        state_q    <= DONE;
                    end else begin
                        scanIdx_q <= scanIdx_q + 1'b1;
                    end
                end
                DONE: begin
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q == COLLECT) || (state_q == SCAN);
    assign result_valid = (state_q == DONE);
    assign winner_idx   = winnerIdx_q;
    assign winner_cnt   = winnerCnt_q;
    assign tie          = tie_q;
    assign majority     = majority_q;

endmodule

// File: tb/tb_vote_tally_seq.sv
// ---------------------------------------------------------------------------
// tb_vote_tally_seq
// Directed bench for vote_tally_seq (4 candidates, 15 voters). Inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_vote_tally_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic       close;
    logic       ballot_valid;
    logic       ballot_ready;
    logic [3:0] ballot;
    logic [3:0] accepted_cnt;
    logic [3:0] rejected_cnt;
    logic       busy;
    logic       result_valid;
    logic [1:0] winner_idx;
    logic [3:0] winner_cnt;
    logic       tie;
    logic       majority;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int lat;

    vote_tally_seq #(.NUM_CAND(4), .MAX_VOTERS(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .close        (close),
        .ballot_valid (ballot_valid),
        .ballot_ready (ballot_ready),
        .ballot       (ballot),
        .accepted_cnt (accepted_cnt),
        .rejected_cnt (rejected_cnt),
        .busy         (busy),
        .result_valid (result_valid),
        .winner_idx   (winner_idx),
        .winner_cnt   (winner_cnt),
        .tie          (tie),
        .majority     (majority)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts, asserts, reports on failure.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one ballot for one clock edge.
    task automatic applyStimulus(input logic [3:0] b);
        ballot_valid = 1'b1;
        ballot       = b;
        tick();
        ballot_valid = 1'b0;
        ballot       = 4'b0000;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges from close (inclusive) until result_valid, bounded.
    task automatic closeAndWait(output int n);
        close = 1'b1;
        tick();
        close = 1'b0;
        n = 1;
        while (!result_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic waitResult(output int n);
        n = 0;
        while (!result_valid && n < 30) begin
            tick();
            n++;
        end
    endtask

    task automatic checkResult(input string tag, input int idx, input int cnt,
                               input int t, input int maj);
        checkOutput({tag, ".valid"},    int'(result_valid), 1);
        checkOutput({tag, ".idx"},      int'(winner_idx),   idx);
        checkOutput({tag, ".cnt"},      int'(winner_cnt),   cnt);
        checkOutput({tag, ".tie"},      int'(tie),          t);
        checkOutput({tag, ".majority"}, int'(majority),     maj);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        close        = 1'b0;
        ballot_valid = 1'b0;
        ballot       = 4'b0000;
        tick();
        tick();

        // Reset state
        checkOutput("rst.ready",    int'(ballot_ready), 0);
        checkOutput("rst.busy",     int'(busy),         0);
        checkOutput("rst.valid",    int'(result_valid), 0);
        checkOutput("rst.accepted", int'(accepted_cnt), 0);
        checkOutput("rst.rejected", int'(rejected_cnt), 0);
        checkOutput("rst.idx",      int'(winner_idx),   0);
        checkOutput("rst.cnt",      int'(winner_cnt),   0);
        checkOutput("rst.tie",      int'(tie),          0);
        checkOutput("rst.majority", int'(majority),     0);
        rst = 1'b0;
        tick();
        checkOutput("idle.ready", int'(ballot_ready), 0);

        // Election 1: candidate 1 wins 4 of 7
        pulseStart();
        checkOutput("e1.busy",  int'(busy),         1);
        checkOutput("e1.ready", int'(ballot_ready), 1);
        applyStimulus(4'b0010);
        applyStimulus(4'b0010);
        applyStimulus(4'b0010);
        applyStimulus(4'b0001);
        applyStimulus(4'b0100);
        applyStimulus(4'b0010);
        applyStimulus(4'b1000);
        checkOutput("e1.accepted", int'(accepted_cnt), 7);
        closeAndWait(lat);
        checkOutput("e1.latency", lat, 5);
        checkResult("e1", 1, 4, 0, 1);
        checkOutput("e1.acceptedDone", int'(accepted_cnt), 7);
        checkOutput("e1.busyDone",     int'(busy),         0);
        // Ballots and close in DONE are ignored
        applyStimulus(4'b0001);
        close = 1'b1;
        tick();
        close = 1'b0;
        checkOutput("e1.doneAccepted", int'(accepted_cnt), 7);
        checkResult("e1hold", 1, 4, 0, 1);

        // Election 2: two-way tie, lower index wins, no majority
        pulseStart();
        checkOutput("e2.validCleared", int'(result_valid), 0);
        checkOutput("e2.cntCleared",   int'(winner_cnt),   0);
        checkOutput("e2.accCleared",   int'(accepted_cnt), 0);
        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        closeAndWait(lat);
        checkResult("e2", 0, 2, 1, 0);

        // Election 3: malformed ballots are rejected
        pulseStart();
        applyStimulus(4'b0100);
        applyStimulus(4'b0000);
        applyStimulus(4'b0100);
        applyStimulus(4'b0110);
        applyStimulus(4'b0100);
        checkOutput("e3.rejected", int'(rejected_cnt), 2);
        checkOutput("e3.accepted", int'(accepted_cnt), 3);
        closeAndWait(lat);
        checkResult("e3", 2, 3, 0, 1);

        // Election 4: voter limit reached with ballot_valid held high
        pulseStart();
        ballot_valid = 1'b1;
        ballot       = 4'b1000;
        repeat (15) tick();
        checkOutput("e4.accepted15", int'(accepted_cnt), 15);
        checkOutput("e4.readyLow",   int'(ballot_ready), 0);
        tick();
        checkOutput("e4.accepted16", int'(accepted_cnt), 15);
        checkOutput("e4.rejected",   int'(rejected_cnt), 0);
        checkOutput("e4.busy",       int'(busy),         1);
        ballot_valid = 1'b0;
        ballot       = 4'b0000;
        waitResult(lat);
        checkResult("e4", 3, 15, 0, 1);

        // Election 5: no ballots at all
        pulseStart();
        closeAndWait(lat);
        checkOutput("e5.latency", lat, 5);
        checkResult("e5", 0, 0, 1, 0);

        // Asynchronous reset in the middle of collection
        pulseStart();
        applyStimulus(4'b0001);
        applyStimulus(4'b0010);
        applyStimulus(4'b0100);
        checkOutput("e6.acceptedPre", int'(accepted_cnt), 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("e6.accepted", int'(accepted_cnt), 0);
        checkOutput("e6.busy",     int'(busy),         0);
        checkOutput("e6.ready",    int'(ballot_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        checkOutput("e6.idleReady", int'(ballot_ready), 0);
        checkOutput("e6.idleBusy",  int'(busy),         0);

        // start during SCAN aborts and reopens collection
        pulseStart();
        applyStimulus(4'b0001);
        applyStimulus(4'b0001);
        close = 1'b1;
        tick();
        close = 1'b0;
        tick();
        pulseStart();
        checkOutput("e7.ready",    int'(ballot_ready), 1);
        checkOutput("e7.busy",     int'(busy),         1);
        checkOutput("e7.accepted", int'(accepted_cnt), 0);
        checkOutput("e7.valid",    int'(result_valid), 0);
        closeAndWait(lat);
        checkResult("e7", 0, 0, 1, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vote_tally_seq.md
Name: vote_tally_seq

Overview:
- Sequential, parametrised plurality/majority vote tallier for the MPC voting benchmark family.
- Accepts one-hot ballots over a valid/ready stream and keeps one saturating counter per candidate.
- On close, scans the counters serially and reports the winner index, winner count, a tie flag and a strict-majority flag.
- Sits between the ballot source and the result consumer; it generalises the fixed single-round, 4-candidate combinational voter to arbitrary candidate/voter counts with streaming input.

Parameters:
NUM_CAND, 4, number of candidates (>=2)
MAX_VOTERS, 15, maximum ballots accepted per election (>=1)
CNT_W, $clog2(MAX_VOTERS+1), width of each tally counter (derived; do not override)
IDX_W, $clog2(NUM_CAND), width of the candidate index (derived; minimum 1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse: clear all tallies and open an election
close  in  1  one-cycle pulse: end ballot collection early
ballot_valid  in  1  ballot present
ballot_ready  out  1  block accepts a ballot this cycle
ballot  in  NUM_CAND  one-hot candidate selection
accepted_cnt  out  CNT_W  number of valid ballots counted
rejected_cnt  out  CNT_W  number of malformed ballots (zero-hot or multi-hot), saturating
busy  out  1  high in COLLECT and SCAN
result_valid  out  1  high in DONE
winner_idx  out  IDX_W  index of the candidate with the highest tally
winner_cnt  out  CNT_W  tally of the winner
tie  out  1  another candidate has a tally equal to winner_cnt
majority  out  1  2*winner_cnt > accepted_cnt

Behaviour:
- Reset (async, active-high): state IDLE; all tallies, accepted_cnt, rejected_cnt, winner_idx, winner_cnt, tie and majority are 0; ballot_ready=0, busy=0, result_valid=0.
- FSM states: IDLE, COLLECT, SCAN, DONE.
- IDLE:
  - start -> COLLECT next cycle.
  - start clears the tallies, both counters and all result outputs.
- COLLECT:
  - ballot_ready=1 while accepted_cnt < MAX_VOTERS.
  - A handshake (valid & ready) with exactly one bit set increments that candidate's tally and accepted_cnt by 1, visible on the next cycle.
  - Zero-hot or multi-hot ballots are consumed, increment rejected_cnt (saturates at all-ones) and leave the tallies untouched.
  - Transition to SCAN when close=1, or in the cycle after accepted_cnt reaches MAX_VOTERS.
  - If close coincides with a handshake, the ballot is counted first, then SCAN.
  - ballot_ready=0 from SCAN onward.
- SCAN:
  - Examines candidate i=0..NUM_CAND-1, one per cycle, so SCAN lasts exactly NUM_CAND cycles.
  - i=0 loads winner_idx=0, winner_cnt=tally[0], tie=0.
  - For i>0: tally[i] > winner_cnt updates the winner and clears tie; tally[i] == winner_cnt sets tie and keeps the lower index.
  - After the last candidate, majority is computed as ({winner_cnt,1'b0} > {1'b0,accepted_cnt}), using CNT_W+1 bits with no overflow, and the FSM enters DONE.
- DONE:
  - result_valid=1; results held stable.
  - start -> COLLECT with everything cleared. close is ignored.
- start in COLLECT or SCAN aborts the election: all state is cleared and the FSM re-enters COLLECT.
- close in IDLE or DONE is ignored. ballot_valid outside COLLECT is never accepted.
- Zero accepted ballots: winner_idx=0, winner_cnt=0, tie=1, majority=0.
- Latency: close -> result_valid is NUM_CAND+1 cycles.
- Asynchronous reset mid-operation discards everything; the next election requires start.

Decomposition:
- Package vote_pkg:
  - state enum typedef (IDLE/COLLECT/SCAN/DONE)
  - function onehot_check (returns is_onehot and index)
  - function clog2_min1
- Sub-module vote_counter_sat: CNT_W-bit counter with clear, increment and saturate; instantiated NUM_CAND+2 times (per-candidate tallies, accepted_cnt, rejected_cnt).

Test Plan:
- NUM_CAND=4, MAX_VOTERS=15: start, 7 ballots (0010,0010,0010,0001,0100,0010,1000), close -> winner_idx=1, winner_cnt=4, tie=0, majority=1, accepted_cnt=7; result_valid rises 5 cycles after close.
- Ballots 0001,0010,0001,0010, close -> winner_idx=0, winner_cnt=2, tie=1, majority=0.
- Ballots 0000 and 0110 mixed with 3x 0100 -> rejected_cnt=2, accepted_cnt=3, winner_idx=2, majority=1.
- 16 consecutive valid 1000 ballots with ballot_valid held high -> exactly 15 accepted, ballot_ready=0 after the 15th, SCAN entered with no close, winner_cnt=15, majority=1.
- Start, close with no ballots -> winner_idx=0, winner_cnt=0, tie=1, majority=0.
- rst asserted mid-COLLECT after 3 ballots -> all outputs 0 immediately (asynchronous). start mid-SCAN -> tallies cleared and ballot_ready=1 the next cycle.
